// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 16x oversampled, majority-voted bits, runtime
// parity/stop-bit selection latched at start-bit detection, break detection.
module uart_rx_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clken_i,
  input  logic                 rx_i,
  input  logic [1:0]           parity_mode_i,
  input  logic                 two_stop_i,
  output logic [DATA_BITS-1:0] dout_o,
  output logic                 dout_valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_o,
  output logic                 busy_o
);

  localparam int IDX_W = (DATA_BITS > 8) ? 4 : 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;

  state_t                 state_reg, state_next;
  logic [3:0]             cnt_reg, cnt_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   s7_reg, s7_next;
  logic                   s8_reg, s8_next;
  logic [1:0]             pmode_reg, pmode_next;
  logic                   two_stop_reg, two_stop_next;
  logic                   stop_idx_reg, stop_idx_next;
  logic                   par_bit_reg, par_bit_next;
  logic                   par_err_reg, par_err_next;
  logic                   ferr_acc_reg, ferr_acc_next;
  logic [DATA_BITS-1:0]   dout_reg, dout_next;
  logic                   valid_reg, valid_next;
  logic                   pe_reg, pe_next;
  logic                   fe_reg, fe_next;
  logic                   brk_reg, brk_next;

  logic vote;
  logic par_en;
  logic par_odd;
  logic final_stop;

  // Synchroniser runs every clock so the line is clean before any tick uses it
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s       = sync_reg[SYNC_STAGES-1];
  assign vote       = (s7_reg & s8_reg) | (s7_reg & rx_s) | (s8_reg & rx_s);
  assign par_en     = pmode_reg[0] ^ pmode_reg[1];
  assign par_odd    = (pmode_reg == 2'b10);
  assign final_stop = (stop_idx_reg == two_stop_reg);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    shift_next    = shift_reg;
    s7_next       = s7_reg;
    s8_next       = s8_reg;
    pmode_next    = pmode_reg;
    two_stop_next = two_stop_reg;
    stop_idx_next = stop_idx_reg;
    par_bit_next  = par_bit_reg;
    par_err_next  = par_err_reg;
    ferr_acc_next = ferr_acc_reg;
    dout_next     = dout_reg;
    pe_next       = pe_reg;
    fe_next       = fe_reg;
    brk_next      = brk_reg;
    valid_next    = 1'b0;

    if (clken_i) begin
      cnt_next = cnt_reg + 4'd1;
      if (cnt_reg == 4'd7) s7_next = rx_s;
      if (cnt_reg == 4'd8) s8_next = rx_s;

      case (state_reg)
        IDLE: begin
          cnt_next = 4'd0;
          if (!rx_s) begin
            state_next    = START;
            pmode_next    = parity_mode_i;
            two_stop_next = two_stop_i;
          end
        end
        START: begin
          if (cnt_reg == 4'd9 && vote) begin
            state_next = IDLE;
            cnt_next   = 4'd0;
          end else if (cnt_reg == 4'd15) begin
            state_next    = DATA;
            idx_next      = '0;
            stop_idx_next = 1'b0;
            par_bit_next  = 1'b0;
            par_err_next  = 1'b0;
            ferr_acc_next = 1'b0;
          end
        end
        DATA: begin
          if (cnt_reg == 4'd9) shift_next[idx_reg] = vote;
          if (cnt_reg == 4'd15) begin
            if (idx_reg == LAST_IDX) begin
              state_next = par_en ? PARITY : STOP;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end
        end
        PARITY: begin
          if (cnt_reg == 4'd9) begin
            par_bit_next = vote;
            par_err_next = vote ^ (^shift_reg) ^ par_odd;
          end
          if (cnt_reg == 4'd15) state_next = STOP;
        end
        STOP: begin
          if (cnt_reg == 4'd9) begin
            if (final_stop) begin
              // A break frame has all-zero data and a low stop, so dout and
              // frame error already follow from the general case.
              dout_next  = shift_reg;
              pe_next    = par_en & par_err_reg;
              fe_next    = ferr_acc_reg | ~vote;
              brk_next   = ~(|shift_reg) & ~(par_en & par_bit_reg) & ~vote;
              valid_next = 1'b1;
              state_next = vote ? IDLE : WAIT_IDLE;
              cnt_next   = 4'd0;
            end else begin
              ferr_acc_next = ferr_acc_reg | ~vote;
            end
          end else if (cnt_reg == 4'd15) begin
            stop_idx_next = 1'b1;
          end
        end
        WAIT_IDLE: begin
          cnt_next = 4'd0;
          if (rx_s) state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      idx_reg      <= '0;
      shift_reg    <= '0;
      s7_reg       <= 1'b1;
      s8_reg       <= 1'b1;
      pmode_reg    <= 2'b00;
      two_stop_reg <= 1'b0;
      stop_idx_reg <= 1'b0;
      par_bit_reg  <= 1'b0;
      par_err_reg  <= 1'b0;
      ferr_acc_reg <= 1'b0;
      dout_reg     <= '0;
      valid_reg    <= 1'b0;
      pe_reg       <= 1'b0;
      fe_reg       <= 1'b0;
      brk_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      shift_reg    <= shift_next;
      s7_reg       <= s7_next;
      s8_reg       <= s8_next;
      pmode_reg    <= pmode_next;
      two_stop_reg <= two_stop_next;
      stop_idx_reg <= stop_idx_next;
      par_bit_reg  <= par_bit_next;
      par_err_reg  <= par_err_next;
      ferr_acc_reg <= ferr_acc_next;
      dout_reg     <= dout_next;
      valid_reg    <= valid_next;
      pe_reg       <= pe_next;
      fe_reg       <= fe_next;
      brk_reg      <= brk_next;
    end
  end

  assign dout_o       = dout_reg;
  assign dout_valid_o = valid_reg;
  assign parity_err_o = pe_reg;
  assign frame_err_o  = fe_reg;
  assign break_o      = brk_reg;
  assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8-bit and 5-bit instances, a frame table
// plus hand sequences for break, glitch, spike, baud skew and mid-frame reset.
module tb_uart_rx_cfg;

  localparam int BIT_CLK  = 64;  // 16 ticks x 4 clocks per tick
  localparam int FAST_CLK = 62;  // transmitter about 3% fast

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clken = 1'b0;
  logic [1:0] div = 2'd0;
  logic       rx8 = 1'b1;
  logic       rx5 = 1'b1;
  logic [1:0] parity_mode = 2'b00;
  logic       two_stop = 1'b0;

  logic [7:0] dout8;
  logic       dv8, pe8, fe8, brk8, busy8;
  logic [4:0] dout5;
  logic       dv5, pe5, fe5, brk5, busy5;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [8:0] dout;
    logic       pe, fe, brk, busy;
  } rec_t;

  typedef struct {
    logic [8:0] data;
    logic [1:0] pm;
    logic       ts;
    logic       par_flip;
    logic       stop_low;
    logic [8:0] e_dout;
    logic       e_pe, e_fe, e_brk, e_busy;
  } vec_t;

  rec_t q8[$];
  rec_t q5[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div   <= div + 2'd1;
    clken <= (div == 2'd3);
  end

  uart_rx_cfg #(.DATA_BITS(8), .SYNC_STAGES(2)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .clken_i(clken), .rx_i(rx8),
    .parity_mode_i(parity_mode), .two_stop_i(two_stop),
    .dout_o(dout8), .dout_valid_o(dv8), .parity_err_o(pe8),
    .frame_err_o(fe8), .break_o(brk8), .busy_o(busy8)
  );

  uart_rx_cfg #(.DATA_BITS(5), .SYNC_STAGES(3)) dut5 (
    .clk_i(clk), .rst_n_i(rst_n), .clken_i(clken), .rx_i(rx5),
    .parity_mode_i(parity_mode), .two_stop_i(two_stop),
    .dout_o(dout5), .dout_valid_o(dv5), .parity_err_o(pe5),
    .frame_err_o(fe5), .break_o(brk5), .busy_o(busy5)
  );

  // Every cycle with valid high is a separate record, so a stretched pulse
  // shows up as an extra entry.
  always @(negedge clk) begin
    if (dv8) q8.push_back('{{1'b0, dout8}, pe8, fe8, brk8, busy8});
    if (dv5) q5.push_back('{{4'b0, dout5}, pe5, fe5, brk5, busy5});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx8 = v;
    else rx5 = v;
  endtask

  // Sends one frame; configuration inputs are scrambled after the start bit
  // so the receiver must rely on the values latched at start detection.
  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input logic [1:0] pm, input logic ts, input logic par_flip,
                            input logic stop_low, input int spike_bit, input int period);
    logic p;
    p = 1'b0;
    for (int i = 0; i < nbits; i++) p ^= data[i];
    if (pm == 2'b10) p = ~p;
    p ^= par_flip;
    parity_mode = pm;
    two_stop    = ts;
    set_rx(which, 1'b0);
    wait_clk(period);
    parity_mode = ~pm;
    two_stop    = ~ts;
    for (int i = 0; i < nbits; i++) begin
      set_rx(which, data[i]);
      if (i == spike_bit) begin
        wait_clk(34);
        set_rx(which, 1'b0);
        wait_clk(4);
        set_rx(which, data[i]);
        wait_clk(period - 38);
      end else begin
        wait_clk(period);
      end
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      set_rx(which, p);
      wait_clk(period);
    end
    if (ts) begin
      set_rx(which, 1'b1);
      wait_clk(period);
    end
    set_rx(which, ~stop_low);
    wait_clk(period);
    set_rx(which, 1'b1);
  endtask

  initial begin
    rec_t r;
    vecs[0] = '{9'h0A5, 2'b00, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{9'h007, 2'b01, 1'b0, 1'b1, 1'b0, 9'h007, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{9'h03C, 2'b10, 1'b1, 1'b0, 1'b1, 9'h03C, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{9'h000, 2'b00, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{9'h0FF, 2'b10, 1'b0, 1'b0, 1'b0, 9'h0FF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{9'h05A, 2'b11, 1'b0, 1'b0, 1'b0, 9'h05A, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{9'h081, 2'b01, 1'b1, 1'b0, 1'b0, 9'h081, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{9'h001, 2'b00, 1'b0, 1'b0, 1'b1, 9'h001, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{9'h000, 2'b01, 1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{9'h0C3, 2'b10, 1'b0, 1'b1, 1'b0, 9'h0C3, 1'b1, 1'b0, 1'b0, 1'b0};

    wait_clk(10);
    check("reset_dout8", {24'd0, dout8}, 32'd0);
    check("reset_valid8", {31'd0, dv8}, 32'd0);
    check("reset_flags8", {29'd0, pe8, fe8, brk8}, 32'd0);
    check("reset_busy8", {31'd0, busy8}, 32'd0);
    check("reset_dout5", {27'd0, dout5}, 32'd0);
    rst_n = 1'b1;
    wait_clk(2 * BIT_CLK);

    for (int v = 0; v < 10; v++) begin
      q8.delete();
      send_frame(0, vecs[v].data, 8, vecs[v].pm, vecs[v].ts, vecs[v].par_flip,
                 vecs[v].stop_low, -1, BIT_CLK);
      wait_clk(2 * BIT_CLK);
      check($sformatf("v%0d_pulses", v), q8.size(), 32'd1);
      r = (q8.size() > 0) ? q8[0] : '{9'h1FF, 1'bx, 1'bx, 1'bx, 1'bx};
      check($sformatf("v%0d_dout", v), {23'd0, r.dout}, {23'd0, vecs[v].e_dout});
      check($sformatf("v%0d_flags", v), {29'd0, r.pe, r.fe, r.brk},
            {29'd0, vecs[v].e_pe, vecs[v].e_fe, vecs[v].e_brk});
      check($sformatf("v%0d_busy_at_pulse", v), {31'd0, r.busy}, {31'd0, vecs[v].e_busy});
      check($sformatf("v%0d_dout_hold", v), {24'd0, dout8}, {23'd0, vecs[v].e_dout});
      check($sformatf("v%0d_busy_after", v), {31'd0, busy8}, 32'd0);
    end

    // Line held low for three frame times, then a normal frame
    q8.delete();
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    rx8 = 1'b0;
    wait_clk(30 * BIT_CLK);
    rx8 = 1'b1;
    wait_clk(2 * BIT_CLK);
    send_frame(0, 9'h055, 8, 2'b00, 1'b0, 1'b0, 1'b0, -1, BIT_CLK);
    wait_clk(2 * BIT_CLK);
    check("break_pulses", q8.size(), 32'd2);
    r = (q8.size() > 0) ? q8[0] : '{9'h1FF, 1'bx, 1'bx, 1'bx, 1'bx};
    check("break_rec", {19'd0, r.dout, r.pe, r.fe, r.brk, r.busy}, {19'd0, 9'h000, 4'b0111});
    r = (q8.size() > 1) ? q8[1] : '{9'h1FF, 1'bx, 1'bx, 1'bx, 1'bx};
    check("after_break_rec", {19'd0, r.dout, r.pe, r.fe, r.brk, r.busy}, {19'd0, 9'h055, 4'b0000});

    // Six-tick start glitch
    q8.delete();
    rx8 = 1'b0;
    wait_clk(16);
    check("glitch_busy_high", {31'd0, busy8}, 32'd1);
    wait_clk(8);
    rx8 = 1'b1;
    wait_clk(3 * BIT_CLK);
    check("glitch_pulses", q8.size(), 32'd0);
    check("glitch_busy_low", {31'd0, busy8}, 32'd0);

    // One-tick low spike in the middle of data bit 3
    send_frame(0, 9'h0FF, 8, 2'b00, 1'b0, 1'b0, 1'b0, 3, BIT_CLK);
    wait_clk(2 * BIT_CLK);
    check("spike_pulses", q8.size(), 32'd1);
    r = (q8.size() > 0) ? q8[0] : '{9'h1FF, 1'bx, 1'bx, 1'bx, 1'bx};
    check("spike_rec", {19'd0, r.dout, r.pe, r.fe, r.brk, r.busy}, {19'd0, 9'h0FF, 4'b0000});

    // 5-bit receiver, back-to-back frames with a fast transmitter
    q5.delete();
    send_frame(1, 9'h01F, 5, 2'b00, 1'b0, 1'b0, 1'b0, -1, FAST_CLK);
    send_frame(1, 9'h00A, 5, 2'b00, 1'b0, 1'b0, 1'b0, -1, FAST_CLK);
    wait_clk(2 * BIT_CLK);
    check("fast_pulses", q5.size(), 32'd2);
    r = (q5.size() > 0) ? q5[0] : '{9'h1FF, 1'bx, 1'bx, 1'bx, 1'bx};
    check("fast_rec0", {19'd0, r.dout, r.pe, r.fe, r.brk, r.busy}, {19'd0, 9'h01F, 4'b0000});
    r = (q5.size() > 1) ? q5[1] : '{9'h1FF, 1'bx, 1'bx, 1'bx, 1'bx};
    check("fast_rec1", {19'd0, r.dout, r.pe, r.fe, r.brk, r.busy}, {19'd0, 9'h00A, 4'b0000});

    // Reset pulsed during data bit 2 of the second frame (line high there)
    q5.delete();
    fork
      begin
        send_frame(1, 9'h00A, 5, 2'b00, 1'b0, 1'b0, 1'b0, -1, FAST_CLK);
        send_frame(1, 9'h01F, 5, 2'b00, 1'b0, 1'b0, 1'b0, -1, FAST_CLK);
      end
      begin
        wait_clk(7 * FAST_CLK + 3 * FAST_CLK + FAST_CLK / 2);
        check("midframe_busy_before_rst", {31'd0, busy5}, 32'd1);
        #2 rst_n = 1'b0;
        wait_clk(3);
        check("midframe_rst_busy", {31'd0, busy5}, 32'd0);
        check("midframe_rst_dout", {27'd0, dout5}, 32'd0);
        rst_n = 1'b1;
      end
    join
    wait_clk(3 * BIT_CLK);
    check("midframe_pulses", q5.size(), 32'd1);
    r = (q5.size() > 0) ? q5[0] : '{9'h1FF, 1'bx, 1'bx, 1'bx, 1'bx};
    check("midframe_rec0", {23'd0, r.dout}, {23'd0, 9'h00A});
    check("midframe_idle", {31'd0, busy5}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame; the legal range is 5..9.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the flip-flop depth of the rx_i synchroniser; the legal range is 2..3.
REQ-003 clk_i  input  1  System clock.
REQ-004 rst_n_i  input  1  Reset, asynchronous, active-low.
REQ-005 clken_i  input  1  16x-baud sample strobe, one clk_i cycle wide.
REQ-006 rx_i  input  1  Serial line, idle high, asynchronous to clk_i.
REQ-007 parity_mode_i  input  2  Parity mode: 00 none, 01 even, 10 odd, 11 none.
REQ-008 two_stop_i  input  1  0 selects one stop bit, 1 selects two stop bits.
REQ-009 dout_o  output  DATA_BITS  Received word, LSB first on the line.
REQ-010 dout_valid_o  output  1  One-cycle pulse; dout_o and the error flags are valid in that cycle.
REQ-011 parity_err_o  output  1  Parity mismatch on the current word; qualified by dout_valid_o.
REQ-012 frame_err_o  output  1  A stop bit was sampled low; qualified by dout_valid_o.
REQ-013 break_o  output  1  Break detected; qualified by dout_valid_o.
REQ-014 busy_o  output  1  High whenever the state is not IDLE.

Function
REQ-015 rx_i SHALL pass through SYNC_STAGES flip-flops, each reset to 1, before use; the result is rx_s.
REQ-016 All state, counter and sample updates SHALL occur only in clk_i cycles where clken_i=1, except the dout_valid_o deassertion.
REQ-017 The state machine SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-018 Sample counter: 4 bits, wraps 15->0; each bit occupies 16 ticks.
REQ-019 Bit value: majority vote of rx_s at counts 7, 8 and 9, resolved at count 9.
REQ-020 IDLE: on a tick with rx_s=0, go to START, clear the counter to 0, and latch parity_mode_i and two_stop_i.
REQ-021 Configuration changes mid-frame SHALL be ignored until the next START entry.
REQ-022 START: if the vote at count 9 is 1, treat it as a glitch, return to IDLE and produce no output.
REQ-023 START: otherwise continue to count 15, then go to DATA with bit index 0.
REQ-024 DATA: the vote at count 9 SHALL be written to shift position bit index.
REQ-025 DATA: after bit DATA_BITS-1 reaches count 15, go to PARITY if parity is enabled, otherwise to STOP.
REQ-026 PARITY: expected value is XOR of the data bits for even parity, or its inverse for odd parity.
REQ-027 PARITY: a mismatch SHALL set an internal parity error flag; at count 15, go to STOP.
REQ-028 STOP: vote each stop bit at count 9; any stop bit that votes 0 SHALL set frame error.
REQ-029 STOP: with two_stop latched, the first stop bit runs to count 15 and the second is then voted.
REQ-030 Output: on the tick where the final stop bit is voted, the registered outputs SHALL update and dout_valid_o SHALL pulse high for exactly one clk_i cycle, starting one clk_i cycle after that tick.
REQ-031 After the output tick, go to IDLE if the final stop vote is 1, otherwise to WAIT_IDLE.
REQ-032 Early return at count 9 gives a 7-tick margin for baud-rate mismatch.
REQ-033 break_o SHALL be set when all data bits, the parity bit (if enabled) and the final stop bit are all 0.
REQ-034 When break_o is set, frame_err_o SHALL also be set and dout_o SHALL be 0.
REQ-035 WAIT_IDLE: stay until a tick with rx_s=1, then go to IDLE; a held-low line therefore produces exactly one break report.
REQ-036 dout_o and the error flags SHALL hold their values until the next dout_valid_o pulse.
REQ-037 If clken_i=0 indefinitely, all state SHALL freeze and dout_valid_o SHALL be 0.
REQ-038 Unsupported parity_mode_i value 11 SHALL behave as none.
REQ-039 End-to-end latency from the rx_i start edge to dout_valid_o is the frame length in bit periods minus 7 ticks, plus SYNC_STAGES+1 clk_i cycles.

Reset
REQ-040 On rst_n_i=0, asynchronously: state IDLE, counter 0, bit index 0, shift register 0, synchroniser all 1, dout_o 0, dout_valid_o 0, parity_err_o 0, frame_err_o 0, break_o 0, busy_o 0.
REQ-041 Reset asserted mid-frame SHALL abandon the frame with no output pulse.
REQ-042 After reset release, a line already low SHALL be treated as a start bit.

Verification
REQ-043 8N1, send 0xA5 -> one dout_valid_o pulse, dout_o=0xA5, all error flags 0, busy_o low after the pulse.
REQ-044 8E1, send 0x07 with parity bit 0 -> dout_o=0x07, parity_err_o=1, frame_err_o=0.
REQ-045 8O2, send 0x3C with the second stop bit driven low -> dout_o=0x3C, frame_err_o=1, state reaches WAIT_IDLE and returns to IDLE when the line goes high.
REQ-046 Line low for 3 frame times -> exactly one pulse with break_o=1, frame_err_o=1, dout_o=0; the next valid frame 0x55 is received correctly.
REQ-047 Start glitch of 6 ticks low, then high -> no dout_valid_o, busy_o returns to 0; a single-tick low spike at count 8 of a data bit is outvoted.
REQ-048 DATA_BITS=5 instance, back-to-back frames at transmitter baud +3% (1x = 0x1F, 1x = 0x0A) -> both words received, no errors; rst_n_i pulsed mid-second-frame -> no pulse for that frame.
